// File: rtl/lcd_pkg.sv
// Panel IDs, per-panel active geometry and the fetch FSM encoding, shared by the
// LCD timing driver and the pixel fetch block.
package lcd_pkg;

    localparam logic [15:0] LCD_ID_480_272   = 16'd0;
    localparam logic [15:0] LCD_ID_800_480   = 16'd1;
    localparam logic [15:0] LCD_ID_1024_600  = 16'd2;
    localparam logic [15:0] LCD_ID_1280_800  = 16'd5;

    typedef struct packed {
        logic [10:0] h_disp;
        logic [10:0] v_disp;
    } disp_geom_t;

    localparam disp_geom_t GEOM_480_272  = '{h_disp: 11'd480,  v_disp: 11'd272};
    localparam disp_geom_t GEOM_800_480  = '{h_disp: 11'd800,  v_disp: 11'd480};
    localparam disp_geom_t GEOM_1024_600 = '{h_disp: 11'd1024, v_disp: 11'd600};
    localparam disp_geom_t GEOM_1280_800 = '{h_disp: 11'd1280, v_disp: 11'd800};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESYNC = 2'd2
    } fetch_state_t;

    // Unknown IDs fall back to the smallest panel so the raster never overruns.
    function automatic disp_geom_t lcd_geom(input logic [15:0] id);
        disp_geom_t g;
        case (id)
            LCD_ID_800_480:  g = GEOM_800_480;
            LCD_ID_1024_600: g = GEOM_1024_600;
            LCD_ID_1280_800: g = GEOM_1280_800;
            default:         g = GEOM_480_272;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lcd_win_calc.sv
// Centres an IMG_H x IMG_V image on the panel and flags pixels inside it.
// Purely combinational; no flow control.
module lcd_win_calc #(
    parameter logic [10:0] IMG_H = 11'd640,
    parameter logic [10:0] IMG_V = 11'd480
) (
    input  logic [10:0] h_disp,
    input  logic [10:0] v_disp,
    input  logic        data_req,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic        in_win
);

    logic [10:0] img_w;
    logic [10:0] img_h;
    logic [10:0] x_off;
    logic [10:0] y_off;
    logic [10:0] x_end;
    logic [10:0] y_end;

    // The image is cropped to the panel when it is larger than the panel.
    assign img_w = (IMG_H < h_disp) ? IMG_H : h_disp;
    assign img_h = (IMG_V < v_disp) ? IMG_V : v_disp;
    assign x_off = (h_disp - img_w) >> 1;
    assign y_off = (v_disp - img_h) >> 1;
    assign x_end = x_off + img_w;
    assign y_end = y_off + img_h;

    assign in_win = data_req
                  && (pixel_xpos > x_off) && (pixel_xpos <= x_end)
                  && (pixel_ypos > y_off) && (pixel_ypos <= y_end);

endmodule

// File: rtl/lcd_pixel_fetch.sv
// Pulls image pixels from the frame FIFO inside the centred window, background elsewhere.
// lcd_rgb trails data_req by 1 cycle; reads stop on FIFO empty and resync at frame end.
module lcd_pixel_fetch
    import lcd_pkg::*;
#(
    parameter logic [10:0] IMG_H    = 11'd640,
    parameter logic [10:0] IMG_V    = 11'd480,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] ID_lcd,
    input  logic        data_req,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        rd_load,
    output logic [15:0] lcd_rgb,
    output logic [7:0]  underflow_cnt
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [15:0]  id_q;
    disp_geom_t   geom;
    logic         in_win;
    logic         frame_end;
    logic         underflow;
    logic         id_chg;
    logic         sel_q;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            id_q <= 16'd0;
        end else begin
            id_q <= ID_lcd;
        end
    end

    assign geom   = lcd_geom(id_q);
    assign id_chg = (ID_lcd != id_q);

    lcd_win_calc #(
        .IMG_H (IMG_H),
        .IMG_V (IMG_V)
    ) u_win_calc (
        .h_disp     (geom.h_disp),
        .v_disp     (geom.v_disp),
        .data_req   (data_req),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .in_win     (in_win)
    );

    assign frame_end = data_req
                     && (pixel_xpos == geom.h_disp)
                     && (pixel_ypos == geom.v_disp);

    assign underflow = (state_q == ACTIVE) && in_win && fifo_empty;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame end wins over underflow; a panel change overrides everything.
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                fifo_rd_en = in_win & ~fifo_empty;
                if (frame_end) begin
                    state_d = ACTIVE;
                end else if (underflow) begin
                    state_d = RESYNC;
                end
            end
            RESYNC: begin
                if (frame_end) begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (id_chg) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_load       <= 1'b0;
            sel_q         <= 1'b0;
            underflow_cnt <= 8'd0;
        end else begin
            rd_load <= frame_end & ~id_chg;
            sel_q   <= fifo_rd_en;
            if (underflow && (underflow_cnt != 8'hFF)) begin
                underflow_cnt <= underflow_cnt + 8'd1;
            end
        end
    end

    // FIFO data arrives one cycle after the strobe, exactly when sel_q is set.
    assign lcd_rgb = sel_q ? fifo_rd_data : BG_COLOR;

endmodule

// File: doc/lcd_pixel_fetch.md
LCD_PIXEL_FETCH -- requirements
Module: lcd_pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_H, default 11'd640, giving the source image width in pixels.
REQ-002 SHALL have parameter IMG_V, default 11'd480, giving the source image height in lines.
REQ-003 SHALL have parameter BG_COLOR, default 16'h0000, giving the RGB565 colour for pixels outside the image window.
REQ-004 lcd_clk  in  1  pixel clock; every register SHALL be clocked on its rising edge.
REQ-005 sys_rst_n  in  1  reset: asynchronous, active-low.
REQ-006 ID_lcd  in  16  panel ID: 0 = 480x272, 1 = 800x480, 2 = 1024x600, 5 = 1280x800; any other value SHALL be treated as 480x272.
REQ-007 data_req  in  1  pixel request; it leads display enable by one cycle.
REQ-008 pixel_xpos  in  11  1-based column (1..h_disp) while data_req=1.
REQ-009 pixel_ypos  in  11  1-based line (1..v_disp) while data_req=1.
REQ-010 fifo_rd_en  out  1  read strobe to the frame FIFO, which returns data the next cycle.
REQ-011 fifo_rd_data  in  16  RGB565 data from the FIFO.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 rd_load  out  1  one-cycle pulse requesting the FIFO controller to restart its frame read address.
REQ-014 lcd_rgb  out  16  RGB565 pixel, aligned with display enable.
REQ-015 underflow_cnt  out  8  saturating count of underflow events.

Function
REQ-016 h_disp and v_disp SHALL be decoded from a registered copy of ID_lcd.
- img_w = min(IMG_H, h_disp); img_h = min(IMG_V, v_disp).
- x_off = (h_disp - img_w) >> 1; y_off = (v_disp - img_h) >> 1.
REQ-017 in_win SHALL be 1 when data_req=1, x_off < pixel_xpos <= x_off+img_w, and y_off < pixel_ypos <= y_off+img_h.
REQ-018 frame_end SHALL be 1 when data_req=1, pixel_xpos == h_disp and pixel_ypos == v_disp.
REQ-019 The FSM SHALL have exactly three states: IDLE, ACTIVE and RESYNC.
REQ-020 In IDLE:
- fifo_rd_en = 0.
- On frame_end, rd_load SHALL pulse on the next cycle and the FSM SHALL move to ACTIVE.
REQ-021 In ACTIVE:
- fifo_rd_en = in_win & ~fifo_empty (combinational).
- On frame_end, rd_load SHALL pulse on the next cycle and the FSM SHALL stay in ACTIVE.
REQ-022 Underflow (ACTIVE, in_win=1, fifo_empty=1):
- underflow_cnt SHALL increment, saturating at 255.
- The FSM SHALL move to RESYNC.
REQ-023 In RESYNC:
- fifo_rd_en = 0.
- On frame_end, rd_load SHALL pulse on the next cycle and the FSM SHALL move to ACTIVE.
REQ-024 If underflow and frame_end coincide, the frame_end transition SHALL take priority: rd_load pulses, the FSM goes to ACTIVE, and the counter still increments.
REQ-025 A change in registered ID_lcd SHALL force IDLE on the next cycle, with no rd_load pulse.
REQ-026 sel_q SHALL be a register loaded with fifo_rd_en each cycle.
- lcd_rgb = sel_q ? fifo_rd_data : BG_COLOR.
- Latency from data_req to the matching lcd_rgb SHALL be 1 cycle.
REQ-027 Outside the window, outside active video, and in IDLE or RESYNC, lcd_rgb SHALL equal BG_COLOR one cycle later.
REQ-028 fifo_rd_en SHALL never assert while fifo_empty=1.

Reset
REQ-029 While sys_rst_n=0, outputs SHALL be:
- FSM = IDLE, sel_q = 0.
- rd_load = 0, fifo_rd_en = 0.
- lcd_rgb = BG_COLOR, underflow_cnt = 0.
- Registered ID = 0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately, and after release no FIFO read SHALL occur before the next frame_end.

Structure
REQ-031 The ID constants (0/1/2/5), the per-ID h_disp/v_disp table and the FSM state encoding SHALL reside in shared package lcd_pkg, shared with the LCD timing driver.
REQ-032 The window computation (REQ-016/017) SHALL be a single sub-module lcd_win_calc; all remaining logic SHALL be flat.

Verification
REQ-033 ID=1, IMG 640x480, FIFO never empty -> after first frame_end, rd_load=1 for 1 cycle; per line, fifo_rd_en high for exactly 640 cycles, xpos 81..720; 307200 reads per frame; lcd_rgb = BG_COLOR at xpos 1..80.
REQ-034 ID=0 (480x272) -> img 480x272, offsets 0; every active pixel read; 130560 reads per frame.
REQ-035 fifo_empty forced high at xpos=100, ypos=10 of frame 2 -> underflow_cnt=1; fifo_rd_en=0 for the rest of the frame; rd_load at frame_end; reads resume on frame 3 line 1.
REQ-036 Underflow forced 300 times -> underflow_cnt holds at 255.
REQ-037 ID_lcd changed 1->2 mid-frame -> IDLE with no reads until the next frame_end; then x_off=192, y_off=60.
REQ-038 sys_rst_n pulsed low mid-line -> lcd_rgb=BG_COLOR and fifo_rd_en=0 immediately; no reads until the following frame_end.
